// File: rtl/corr_pkg.sv
// corr_pkg: shared FSM types and elaboration helpers for lag_correlator_stream.
// Build option CORR_AUTO_EN: appends NUM_INPUTS*LAG_CROSS autocorrelation entries.
package corr_pkg;

    typedef enum logic {C_IDLE, C_ACC} ctl_state_t;
    typedef enum logic {O_IDLE, O_STREAM} out_state_t;

    typedef struct packed {
        int a;
        int b;
    } pair_t;

    function automatic int num_baselines(int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int num_entries(int n, int l);
`ifdef CORR_AUTO_EN
        return num_baselines(n) * (2 * l - 1) + n * l;
`else
        return num_baselines(n) * (2 * l - 1);
`endif
    endfunction

    // Baselines are numbered (0,1),(0,2)..(n-2,n-1).
    function automatic pair_t baseline_pair(int idx, int n);
        pair_t p;
        int    k;
        p.a = 0;
        p.b = 1;
        k   = 0;
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                if (k == idx) begin
                    p.a = a;
                    p.b = b;
                end
                k++;
            end
        end
        return p;
    endfunction

    // Add and clamp to a signed range of the given width.
    function automatic longint sat_add(longint acc, longint add, int bits);
        longint s;
        longint hi;
        longint lo;
        s  = acc + add;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/lag_correlator_stream_if.sv
// lag_correlator_stream_if: valid/ready stream carrying correlator frame entries.
// Ports: out_valid/out_data/out_index/out_last from master, out_ready from slave.
interface lag_correlator_stream_if #(
    parameter int RESOLUTION = 24
);
    logic                      out_valid;
    logic                      out_ready;
    logic [2*RESOLUTION-1:0]   out_data;
    logic [15:0]               out_index;
    logic                      out_last;

    modport master (
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/corr_delay_line.sv
// corr_delay_line: per-input I/Q shift register; tap k holds the sample k shifts ago.
// Ports: clk, reset, clear, shift, in_i/in_q, tap_i/tap_q (tap k at [k*W+:W]).
module corr_delay_line #(
    parameter int WORD_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [WORD_WIDTH-1:0]       in_i,
    input  logic [WORD_WIDTH-1:0]       in_q,
    output logic [DEPTH*WORD_WIDTH-1:0] tap_i,
    output logic [DEPTH*WORD_WIDTH-1:0] tap_q
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tap_i <= '0;
            tap_q <= '0;
        end else if (shift) begin
            tap_i[0 +: WORD_WIDTH] <= in_i;
            tap_q[0 +: WORD_WIDTH] <= in_q;
            for (int k = 1; k < DEPTH; k++) begin
                tap_i[k*WORD_WIDTH +: WORD_WIDTH] <= tap_i[(k-1)*WORD_WIDTH +: WORD_WIDTH];
                tap_q[k*WORD_WIDTH +: WORD_WIDTH] <= tap_q[(k-1)*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end
endmodule

// File: rtl/lag_correlator_stream.sv
// lag_correlator_stream: complex lag cross-correlator with snapshot bank streamed out.
// Ports: clk, reset, enable, smp_valid, adc_i/adc_q, integ_len, out_if (master), overflow, busy.
// Build option CORR_AUTO_EN adds autocorrelation entries after the cross entries.
module lag_correlator_stream
    import corr_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WORD_WIDTH = 2,
    parameter int LAG_CROSS  = 4,
    parameter int RESOLUTION = 24,
    parameter int INTEG_BITS = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             smp_valid,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0] adc_i,
    input  logic [NUM_INPUTS*WORD_WIDTH-1:0] adc_q,
    input  logic [INTEG_BITS-1:0]            integ_len,
    lag_correlator_stream_if.master          out_if,
    output logic                             overflow,
    output logic                             busy
);
    localparam int NLAG   = 2 * LAG_CROSS - 1;
    localparam int NCROSS = num_baselines(NUM_INPUTS) * NLAG;
    localparam int NE     = num_entries(NUM_INPUTS, LAG_CROSS);
    localparam int PW     = 2 * WORD_WIDTH + 1;
    localparam int IW     = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [15:0]           LAST_IDX = 16'(NE - 1);
    localparam logic [INTEG_BITS-1:0] LEN_ONE  = INTEG_BITS'(1);

    ctl_state_t state, state_nx;
    out_state_t ostate, ostate_nx;
    logic start, run, accept;
    logic [INTEG_BITS-1:0] len_q, cnt;
    logic cnt_last, s1_v, s1_end, p_v, p_end;
    logic snap, snap_ok, hs, last_hs;
    logic [15:0] idx;

    logic [LAG_CROSS*WORD_WIDTH-1:0] tap_i [NUM_INPUTS];
    logic [LAG_CROSS*WORD_WIDTH-1:0] tap_q [NUM_INPUTS];
    logic signed [PW-1:0] pr_re [NE], pr_im [NE];
    logic signed [PW-1:0] p_re [NE], p_im [NE];
    logic signed [RESOLUTION-1:0] acc_re [NE], acc_im [NE];
    logic signed [RESOLUTION-1:0] sum_re [NE], sum_im [NE];
    logic signed [RESOLUTION-1:0] shd_re [NE], shd_im [NE];

    // Control FSM
    always_ff @(posedge clk) begin
        if (reset) state <= C_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            C_IDLE:  if (enable)  state_nx = C_ACC;
            C_ACC:   if (!enable) state_nx = C_IDLE;
            default: state_nx = C_IDLE;
        endcase
    end

    always_comb begin
        start  = (state == C_IDLE) && enable;
        run    = (state == C_ACC) && enable;
        accept = run && smp_valid;
        busy   = (state == C_ACC);
    end

    assign cnt_last = (cnt == len_q - LEN_ONE);

    // Sample counter; the end flag travels with the last sample's products.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= '0;
            cnt    <= '0;
            s1_v   <= 1'b0;
            s1_end <= 1'b0;
            p_v    <= 1'b0;
            p_end  <= 1'b0;
        end else begin
            if (start) begin
                len_q <= (integ_len == '0) ? LEN_ONE : integ_len;
                cnt   <= '0;
            end else if (accept) begin
                cnt <= cnt_last ? '0 : cnt + LEN_ONE;
            end
            s1_v   <= accept;
            s1_end <= accept && cnt_last;
            p_v    <= s1_v && run;
            p_end  <= s1_end;
        end
    end

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_dl
        corr_delay_line #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (LAG_CROSS)
        ) u_dl (
            .clk   (clk),
            .reset (reset),
            .clear (start),
            .shift (accept),
            .in_i  (adc_i[n*WORD_WIDTH +: WORD_WIDTH]),
            .in_q  (adc_q[n*WORD_WIDTH +: WORD_WIDTH]),
            .tap_i (tap_i[n]),
            .tap_q (tap_q[n])
        );
    end

    // Entry e: cross entries first, then (optionally) per-line autocorrelation.
    for (genvar e = 0; e < NE; e++) begin : g_ent
        localparam bit    IS_X = (e < NCROSS);
        localparam int    K    = e % NLAG - (LAG_CROSS - 1);
        localparam pair_t P    = baseline_pair(e / NLAG, NUM_INPUTS);
        localparam int    LA   = IS_X ? P.a : (e - NCROSS) / LAG_CROSS;
        localparam int    LB   = IS_X ? P.b : LA;
        localparam int    DA   = IS_X ? ((K > 0) ? K : 0) : (e - NCROSS) % LAG_CROSS;
        localparam int    DB   = IS_X ? ((K < 0) ? -K : 0) : 0;

        logic signed [PW-1:0] ia, qa, ib, qb;
        assign ia = PW'(signed'(tap_i[LA][DA*WORD_WIDTH +: WORD_WIDTH]));
        assign qa = PW'(signed'(tap_q[LA][DA*WORD_WIDTH +: WORD_WIDTH]));
        assign ib = PW'(signed'(tap_i[LB][DB*WORD_WIDTH +: WORD_WIDTH]));
        assign qb = PW'(signed'(tap_q[LB][DB*WORD_WIDTH +: WORD_WIDTH]));
        // x_a * conj(x_b)
        assign pr_re[e] = ia * ib + qa * qb;
        assign pr_im[e] = qa * ib - ia * qb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NE; e++) begin
                p_re[e] <= '0;
                p_im[e] <= '0;
            end
        end else if (s1_v) begin
            for (int e = 0; e < NE; e++) begin
                p_re[e] <= pr_re[e];
                p_im[e] <= pr_im[e];
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NE; e++) begin
            sum_re[e] = RESOLUTION'(sat_add(longint'(acc_re[e]), longint'(p_re[e]), RESOLUTION));
            sum_im[e] = RESOLUTION'(sat_add(longint'(acc_im[e]), longint'(p_im[e]), RESOLUTION));
        end
    end

    assign snap    = p_v && p_end && run;
    assign hs      = out_if.out_valid && out_if.out_ready;
    assign last_hs = hs && out_if.out_last;
    assign snap_ok = (ostate == O_IDLE) || last_hs;

    // The final product lands in the shadow copy while the live bank restarts at 0.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            for (int e = 0; e < NE; e++) begin
                acc_re[e] <= '0;
                acc_im[e] <= '0;
            end
        end else if (p_v && run) begin
            for (int e = 0; e < NE; e++) begin
                acc_re[e] <= p_end ? '0 : sum_re[e];
                acc_im[e] <= p_end ? '0 : sum_im[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NE; e++) begin
                shd_re[e] <= '0;
                shd_im[e] <= '0;
            end
        end else if (snap && snap_ok) begin
            for (int e = 0; e < NE; e++) begin
                shd_re[e] <= sum_re[e];
                shd_im[e] <= sum_im[e];
            end
        end
    end

    // Output FSM
    always_ff @(posedge clk) begin
        if (reset) ostate <= O_IDLE;
        else       ostate <= ostate_nx;
    end

    always_comb begin
        ostate_nx = ostate;
        unique case (ostate)
            O_IDLE:   if (snap) ostate_nx = O_STREAM;
            O_STREAM: if (last_hs) ostate_nx = snap ? O_STREAM : O_IDLE;
            default:  ostate_nx = O_IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid = (ostate == O_STREAM);
        out_if.out_index = idx;
        out_if.out_last  = (ostate == O_STREAM) && (idx == LAST_IDX);
        out_if.out_data  = {shd_im[idx[IW-1:0]], shd_re[idx[IW-1:0]]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (last_hs)  idx <= '0;
            else if (hs)  idx <= idx + 16'd1;
            if (snap && !snap_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lag_correlator_stream.sv
// tb_lag_correlator_stream: randomized scoreboard bench for lag_correlator_stream.
// A sample-history model predicts each frame; a monitor checks entries as they stream.
module tb_lag_correlator_stream;
    localparam int NI = 3;
    localparam int W  = 2;
    localparam int L  = 2;
    localparam int R  = 6;
    localparam int IB = 8;
    localparam int HI = (1 << (R - 1)) - 1;
    localparam int LO = -(1 << (R - 1));

    typedef struct {
        logic [2*R-1:0] data;
        int             idx;
        bit             last;
    } exp_t;

    logic clk = 1'b0;
    logic reset, enable, smp_valid;
    logic [NI*W-1:0] adc_i, adc_q;
    logic [IB-1:0]   integ_len;
    logic overflow, busy;

    lag_correlator_stream_if #(.RESOLUTION(R)) oif ();

    lag_correlator_stream #(
        .NUM_INPUTS (NI),
        .WORD_WIDTH (W),
        .LAG_CROSS  (L),
        .RESOLUTION (R),
        .INTEG_BITS (IB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .smp_valid (smp_valid),
        .adc_i     (adc_i),
        .adc_q     (adc_q),
        .integ_len (integ_len),
        .out_if    (oif.master),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rmode  = 1;
    bit mon_on = 0;

    exp_t expq[$];
    int ea[$], eb[$], eda[$], edb[$];
    int hist_i[$], hist_q[$];
    int cur_i[NI], cur_q[NI];
    int seg, cnt, len_eff, frames;
    bit drop_next;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    function automatic int gi(int s, int n);
        if (s < 0) return 0;
        return hist_i[s*NI+n];
    endfunction

    function automatic int gq(int s, int n);
        if (s < 0) return 0;
        return hist_q[s*NI+n];
    endfunction

    // Frame entry = sum over this integration of x_a[s-da] * conj(x_b[s-db]), clamped per add.
    task automatic close_frame();
        int ns, ne, re, im, ia, qa, ib, qb;
        logic [R-1:0] rr, mm;
        exp_t x;
        ns = hist_i.size() / NI;
        ne = ea.size();
        for (int e = 0; e < ne; e++) begin
            re = 0;
            im = 0;
            for (int s = seg; s < ns; s++) begin
                ia = gi(s - eda[e], ea[e]);
                qa = gq(s - eda[e], ea[e]);
                ib = gi(s - edb[e], eb[e]);
                qb = gq(s - edb[e], eb[e]);
                re = clamp(re + ia * ib + qa * qb);
                im = clamp(im + qa * ib - ia * qb);
            end
            rr = re[R-1:0];
            mm = im[R-1:0];
            x.data = {mm, rr};
            x.idx  = e;
            x.last = (e == ne - 1);
            if (!drop_next) expq.push_back(x);
        end
        drop_next = 0;
        frames++;
        seg = ns;
    endtask

    task automatic step(bit v);
        for (int n = 0; n < NI; n++) begin
            adc_i[n*W +: W] = cur_i[n][W-1:0];
            adc_q[n*W +: W] = cur_q[n][W-1:0];
        end
        smp_valid = v;
        @(posedge clk);
        #1;
        smp_valid = 0;
        if (v) begin
            for (int n = 0; n < NI; n++) begin
                hist_i.push_back(cur_i[n]);
                hist_q.push_back(cur_q[n]);
            end
            cnt++;
            if (cnt == len_eff) begin
                close_frame();
                cnt = 0;
            end
        end
    endtask

    task automatic set_all(int vi, int vq);
        for (int n = 0; n < NI; n++) begin
            cur_i[n] = vi;
            cur_q[n] = vq;
        end
    endtask

    task automatic set_rand();
        for (int n = 0; n < NI; n++) begin
            cur_i[n] = int'($urandom_range(0, 3)) - 2;
            cur_q[n] = int'($urandom_range(0, 3)) - 2;
        end
    endtask

    task automatic start_session(int len);
        enable    = 0;
        integ_len = IB'(len);
        @(posedge clk);
        #1 enable = 1;
        @(posedge clk);
        #1;
        hist_i.delete();
        hist_q.delete();
        seg     = 0;
        cnt     = 0;
        len_eff = (len == 0) ? 1 : len;
        chk("busy_in_acc", longint'(busy), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || oif.out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain: %0d entries still pending, expected 0", expq.size());
        end
    endtask

    // Ready driver: 0 random, 1 high, 2 low, 3 toggle, 4 left to the test.
    initial begin
        oif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: oif.out_ready = 1'($urandom_range(0, 1));
                1: oif.out_ready = 1'b1;
                2: oif.out_ready = 1'b0;
                3: oif.out_ready = ~oif.out_ready;
                default: ;
            endcase
        end
    end

    // Monitor: any presented entry must equal the queue head; pop on handshake.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (mon_on && oif.out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream: entry idx=%0d presented, expected no entry",
                             oif.out_index);
                end else begin
                    x = expq[0];
                    if (oif.out_data !== x.data || oif.out_index != 16'(x.idx) ||
                        oif.out_last !== x.last) begin
                        errors++;
                        $display("FAIL stream: got idx=%0d data=%h last=%0b expected idx=%0d data=%h last=%0b",
                                 oif.out_index, oif.out_data, oif.out_last,
                                 x.idx, x.data, x.last);
                    end
                    if (oif.out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        for (int a = 0; a < NI; a++)
            for (int b = a + 1; b < NI; b++)
                for (int k = -(L - 1); k <= L - 1; k++) begin
                    ea.push_back(a);
                    eb.push_back(b);
                    eda.push_back(k > 0 ? k : 0);
                    edb.push_back(k < 0 ? -k : 0);
                end
`ifdef CORR_AUTO_EN
        for (int a = 0; a < NI; a++)
            for (int k = 0; k < L; k++) begin
                ea.push_back(a);
                eb.push_back(a);
                eda.push_back(k);
                edb.push_back(0);
            end
`endif
        frames = 0;
        drop_next = 0;
        reset = 1;
        enable = 0;
        smp_valid = 0;
        adc_i = '0;
        adc_q = '0;
        integ_len = '0;
        set_all(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(oif.out_valid), 0);
        chk("rst_out_index", longint'(oif.out_index), 0);
        chk("rst_out_last", longint'(oif.out_last), 0);
        chk("rst_out_data", longint'(oif.out_data), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_busy", longint'(busy), 0);
        @(posedge clk);
        #1 reset = 0;
        mon_on = 1;

        // Constant +1: lag 0 = +4; off-zero lags see the cleared line first.
        start_session(4);
        set_all(1, 0);
        repeat (4) step(1);
        wait_drain();
        repeat (4) step(1);
        wait_drain();

        // x = 1+j on every line.
        start_session(3);
        set_all(1, 1);
        repeat (3) step(1);
        wait_drain();

        // x1 = j*x0: baseline (0,1) lag 0 imag = -integ_len.
        start_session(5);
        cur_i[0] = 1; cur_q[0] = 0;
        cur_i[1] = 0; cur_q[1] = 1;
        cur_i[2] = -1; cur_q[2] = 0;
        repeat (5) step(1);
        wait_drain();

        // Long integration saturates at +HI without wrapping.
        start_session(40);
        set_all(1, 0);
        repeat (40) step(1);
        wait_drain();

        // Ready toggling each cycle.
        rmode = 3;
        start_session(3);
        repeat (3) begin set_rand(); step(1); end
        wait_drain();
        rmode = 1;

        // integ_len = 0 behaves as 1.
        start_session(0);
        repeat (3) begin set_rand(); step(1); wait_drain(); end

        // Randomized sessions with gaps and random ready.
        rmode = 0;
        repeat (4) begin
            start_session(int'($urandom_range(1, 5)));
            repeat (3) begin
                n = frames + 1;
                while (frames < n) begin
                    set_rand();
                    step($urandom_range(0, 3) != 0);
                end
                wait_drain();
            end
        end

        // Stalled consumer: second snapshot dropped, first frame intact.
        rmode = 2;
        start_session(2);
        repeat (2) begin set_rand(); step(1); end
        drop_next = 1;
        repeat (2) begin set_rand(); step(1); end
        repeat (6) step(0);
        chk("overflow_set", longint'(overflow), 1);
        chk("stall_index", longint'(oif.out_index), 0);
        rmode = 1;
        wait_drain();
        chk("overflow_sticky", longint'(overflow), 1);

        // Reset while index 1 is presented.
        rmode = 4;
        oif.out_ready = 0;
        start_session(2);
        repeat (2) begin set_rand(); step(1); end
        n = 0;
        while (!oif.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_valid_seen", longint'(oif.out_valid), 1);
        oif.out_ready = 1;
        @(posedge clk);
        #1 oif.out_ready = 0;
        chk("mid_index", longint'(oif.out_index), 1);
        reset = 1;
        enable = 0;
        @(posedge clk);
        expq.delete();
        @(negedge clk);
        chk("mid_rst_valid", longint'(oif.out_valid), 0);
        chk("mid_rst_overflow", longint'(overflow), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_index", longint'(oif.out_index), 0);
        @(posedge clk);
        #1 reset = 0;

        // Recovery after reset.
        rmode = 0;
        start_session(2);
        repeat (2) begin set_rand(); step(1); end
        wait_drain();
        chk("final_overflow", longint'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
